gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Shares the single general-register write port between three writeback sources: 0 = integer ALU, 1 = load unit, 2 = move/special unit (mflr, fpr-to-gpr moves).
- Drives the register file write port (w_en, wreg, wdata, w_byte) from a registered stage.
- Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards.

Parameters:
- NREQ, 3, number of writeback requesters (ports are sized for 3; other values are unsupported).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 1 highest, then 0, then 2.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous reset, active-low
- req_valid  in  3  per-requester write request
- req_ready  out  3  per-requester grant; a transfer occurs when valid and ready are both 1
- req_reg  in  15  three 5-bit destination registers; requester i uses bits [5i+4:5i]
- req_data  in  96  three 32-bit write data words; requester i uses bits [32i+31:32i]
- req_byte  in  3  per-requester byte write (only data[7:0] is written)
- w_en  out  1  register file write enable
- wreg  out  5  register file write address
- wdata  out  32  register file write data
- w_byte  out  1  register file byte-write select
- sb_set_en  in  1  issue stage marks a destination register pending
- sb_set_reg  in  5  register to mark pending
- rreg1  in  5  hazard query address 1
- rreg2  in  5  hazard query address 2
- busy1  out  1  rreg1 has a pending write (combinational)
- busy2  out  1  rreg2 has a pending write (combinational)
- idle  out  1  no pending bits set and w_en = 0

Behaviour:
- Reset (rstn = 0 at a clk edge):
  - w_en = 0, wreg = 0, wdata = 0, w_byte = 0.
  - All 32 pending bits cleared; round-robin pointer = 0.
  - req_ready = 0 while rstn = 0.
- Arbitration is combinational and one-hot. At most one req_ready bit is 1, and a bit can only be 1 when the matching req_valid is 1.
- Round-robin: the search starts at the pointer and wraps modulo 3. After a grant to requester g, the pointer becomes (g+1) mod 3. With no grant, the pointer holds.
- Requester hold rules:
  - A requester keeps valid, reg, data and byte stable until it is granted.
  - A requester does not drop valid before it is granted.
- Latency: a grant in cycle N produces w_en = 1 in cycle N+1, with wreg, wdata and w_byte registered from the granted requester.
  - With no grant, w_en = 0 in the next cycle; wreg, wdata and w_byte hold their values.
- Register 0:
  - A granted request to register 0 is accepted (ready = 1).
  - w_en stays 0 in the next cycle and the pending bit is not touched.
- Scoreboard:
  - A grant to register r, with r != 0, clears pending[r] on the same edge that loads the output stage.
  - sb_set_en with sb_set_reg = r, r != 0, sets pending[r].
  - If set and clear hit the same register in the same cycle, set wins: the new producer's write is still outstanding.
  - sb_set_reg = 0 is ignored.
  - busy1 = pending[rreg1]; busy2 = pending[rreg2]. Register 0 always reads not busy.
- Throughput is one write per cycle; there are no bubbles between back-to-back grants.
- Fairness: with RR_EN = 1, a continuously valid requester is granted within 3 cycles.
- When rstn is deasserted mid-operation:
  - Any in-flight output write is dropped (w_en = 0 the next cycle).
  - Requesters re-present their requests after reset.

Optional Feature:
- Macro: GPR_WB_BYPASS_EN.
- When defined, two extra outputs are added:
  - byp_hit1 (1 bit) and byp_hit2 (1 bit): set when w_en = 1, wreg != 0 and wreg equals rreg1 / rreg2.
  - byp_data (32 bits): carries wdata.
  - Issue logic uses these to forward the value being written this cycle.
- When not defined, the bypass ports do not exist.
- Arbitration and scoreboard behaviour are identical in both builds.

Test Plan:
- Reset, then a single request: requester 0 writes reg 5, data 0x0000_1234, with sb_set before it. Required: ready0 = 1 in the grant cycle; next cycle w_en = 1, wreg = 5, wdata = 0x1234, w_byte = 0; pending[5] = 0, so busy1 = 0 when rreg1 = 5.
- All three requesters valid continuously with RR_EN = 1, pointer 0. Required: grants 0, 1, 2, 0, 1, 2 on consecutive cycles; w_en stays high with no gaps.
- RR_EN = 0 with requesters 0 and 1 both valid. Required: requester 1 is granted first, then requester 0.
- Register-0 write: requester 2 writes reg 0, data 0xFFFF_FFFF. Required: ready2 = 1; next cycle w_en = 0.
- Set/clear collision: pending[7] = 1, requester 1 is granted a write to reg 7, and sb_set_en = 1 with sb_set_reg = 7 in the same cycle. Required: pending[7] remains 1 and busy2 = 1 when rreg2 = 7.
- Byte write and mid-operation reset: requester 1 writes reg 3 with req_byte = 1, data 0xAB, and rstn = 0 in the grant cycle. Required: next cycle w_en = 0 and all pending bits are clear. Without reset, the required result is w_byte = 1, wdata[7:0] = 0xAB.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the single GPR write port, with a per-register pending scoreboard.
// Optional forwarding outputs are enabled with `define GPR_WB_BYPASS_EN.
module gpr_wb_arbiter #(
   parameter int unsigned NREQ  = 3,
   parameter bit          RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [2:0]  req_valid,
   output logic [2:0]  req_ready,
   input  logic [14:0] req_reg,
   input  logic [95:0] req_data,
   input  logic [2:0]  req_byte,
   output logic        w_en,
   output logic [4:0]  wreg,
   output logic [31:0] wdata,
   output logic        w_byte,
   input  logic        sb_set_en,
   input  logic [4:0]  sb_set_reg,
   input  logic [4:0]  rreg1,
   input  logic [4:0]  rreg2,
   output logic        busy1,
   output logic        busy2,
   output logic        idle
`ifdef GPR_WB_BYPASS_EN
   ,
   output logic        byp_hit1,
   output logic        byp_hit2,
   output logic [31:0] byp_data
`endif
);

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [31:0] pending_q, pending_d;
   logic        w_en_q, w_en_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;
   logic        w_byte_q, w_byte_d;

   logic [2:0]  grant;
   logic [1:0]  gnt_idx;
   logic        gnt_any;
   logic [1:0]  cand;
   logic [4:0]  g_reg;
   logic [31:0] g_data;
   logic        g_byte;

   // First valid requester in search order wins; nothing is granted while in reset.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (RR_EN) begin
            cand = wrap3({1'b0, rr_ptr_q} + 3'(k));
         end else begin
            case (k)
               0:       cand = 2'd1;
               1:       cand = 2'd0;
               default: cand = 2'd2;
            endcase
         end
         if (!gnt_any && rstn && req_valid[cand]) begin
            gnt_any       = 1'b1;
            grant[cand]   = 1'b1;
            gnt_idx       = cand;
         end
      end
   end

   assign req_ready = grant;

   always_comb begin
      case (gnt_idx)
         2'd0: begin
            g_reg  = req_reg[4:0];
            g_data = req_data[31:0];
            g_byte = req_byte[0];
         end
         2'd1: begin
            g_reg  = req_reg[9:5];
            g_data = req_data[63:32];
            g_byte = req_byte[1];
         end
         default: begin
            g_reg  = req_reg[14:10];
            g_data = req_data[95:64];
            g_byte = req_byte[2];
         end
      endcase
   end

   always_comb begin
      w_en_d    = 1'b0;
      wreg_d    = wreg_q;
      wdata_d   = wdata_q;
      w_byte_d  = w_byte_q;
      rr_ptr_d  = rr_ptr_q;
      pending_d = pending_q;
      if (gnt_any) begin
         w_en_d   = (g_reg != 5'd0);
         wreg_d   = g_reg;
         wdata_d  = g_data;
         w_byte_d = g_byte;
         rr_ptr_d = wrap3({1'b0, gnt_idx} + 3'd1);
         if (g_reg != 5'd0) begin
            pending_d[g_reg] = 1'b0;
         end
      end
      // Set applied after clear: a new producer's write is still outstanding.
      if (sb_set_en && (sb_set_reg != 5'd0)) begin
         pending_d[sb_set_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr_q  <= '0;
         pending_q <= '0;
         w_en_q    <= 1'b0;
         wreg_q    <= '0;
         wdata_q   <= '0;
         w_byte_q  <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         pending_q <= pending_d;
         w_en_q    <= w_en_d;
         wreg_q    <= wreg_d;
         wdata_q   <= wdata_d;
         w_byte_q  <= w_byte_d;
      end
   end

   assign w_en   = w_en_q;
   assign wreg   = wreg_q;
   assign wdata  = wdata_q;
   assign w_byte = w_byte_q;

   // pending_q[0] is never set, so register 0 always reads not busy.
   assign busy1 = pending_q[rreg1];
   assign busy2 = pending_q[rreg2];
   assign idle  = ~(|pending_q) & ~w_en_q;

`ifdef GPR_WB_BYPASS_EN
   assign byp_hit1 = w_en_q && (wreg_q != 5'd0) && (wreg_q == rreg1);
   assign byp_hit2 = w_en_q && (wreg_q != 5'd0) && (wreg_q == rreg2);
   assign byp_data = wdata_q;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: directed stimulus pushes expected writes, a monitor
// pops and compares them whenever the write port fires.
module tb_gpr_wb_arbiter;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
      logic        b;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [2:0]  req_valid, req_ready, req_byte;
   logic [14:0] req_reg;
   logic [95:0] req_data;
   logic        w_en, w_byte, sb_set_en, busy1, busy2, idle;
   logic [4:0]  wreg, sb_set_reg, rreg1, rreg2;
   logic [31:0] wdata;

   logic [2:0]  fp_valid, fp_ready;
   logic [14:0] fp_reg;
   logic [95:0] fp_data;
   logic        fp_w_en, fp_w_byte, fp_busy1, fp_busy2, fp_idle;
   logic [4:0]  fp_wreg;
   logic [31:0] fp_wdata;
   logic [2:0]  zero3 = 3'b000;
   logic        zero1 = 1'b0;
   logic [4:0]  zero5 = 5'd0;
`ifdef GPR_WB_BYPASS_EN
   logic        byp_hit1, byp_hit2, fp_hit1, fp_hit2;
   logic [31:0] byp_data, fp_bdata;
`endif

   int  n_total = 0;
   int  n_fail  = 0;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   gpr_wb_arbiter #(.NREQ(3), .RR_EN(1'b1)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_reg(req_reg), .req_data(req_data), .req_byte(req_byte),
      .w_en(w_en), .wreg(wreg), .wdata(wdata), .w_byte(w_byte),
      .sb_set_en(sb_set_en), .sb_set_reg(sb_set_reg), .rreg1(rreg1), .rreg2(rreg2),
      .busy1(busy1), .busy2(busy2), .idle(idle)
`ifdef GPR_WB_BYPASS_EN
      , .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data)
`endif
   );

   gpr_wb_arbiter #(.NREQ(3), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rstn(rstn), .req_valid(fp_valid), .req_ready(fp_ready),
      .req_reg(fp_reg), .req_data(fp_data), .req_byte(zero3),
      .w_en(fp_w_en), .wreg(fp_wreg), .wdata(fp_wdata), .w_byte(fp_w_byte),
      .sb_set_en(zero1), .sb_set_reg(zero5), .rreg1(zero5), .rreg2(zero5),
      .busy1(fp_busy1), .busy2(fp_busy2), .idle(fp_idle)
`ifdef GPR_WB_BYPASS_EN
      , .byp_hit1(fp_hit1), .byp_hit2(fp_hit2), .byp_data(fp_bdata)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write on the port must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (w_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            n_fail++;
            $display("FAIL unexpected_write: got wreg=%0d wdata=0x%0h, expected no write",
                     wreg, wdata);
         end else begin
            e = exp_q.pop_front();
            chk("sb_wreg", 32'(wreg), 32'(e.r));
            chk("sb_wdata", wdata, e.d);
            chk("sb_w_byte", 32'(w_byte), 32'(e.b));
         end
      end
   end

   initial begin
      rstn       = 1'b0;
      req_valid  = 3'b111;
      req_reg    = {5'd3, 5'd2, 5'd1};
      req_data   = {32'h3, 32'h2, 32'h1};
      req_byte   = 3'b000;
      sb_set_en  = 1'b0;
      sb_set_reg = 5'd0;
      rreg1      = 5'd0;
      rreg2      = 5'd0;
      fp_valid   = 3'b000;
      fp_reg     = '0;
      fp_data    = '0;

      // Reset state
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_w_en", 32'(w_en), 32'h0);
      chk("rst_wreg", 32'(wreg), 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_w_byte", 32'(w_byte), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      step();
      rstn       = 1'b1;
      req_valid  = 3'b000;
      sb_set_en  = 1'b1;
      sb_set_reg = 5'd5;
      step();

      // Single write from requester 0 to reg 5
      sb_set_en = 1'b0;
      rreg1     = 5'd5;
      req_valid = 3'b001;
      req_reg   = {5'd0, 5'd0, 5'd5};
      req_data  = {32'h0, 32'h0, 32'h0000_1234};
      @(negedge clk);
      chk("single_busy_before", 32'(busy1), 32'h1);
      chk("single_idle_before", 32'(idle), 32'h0);
      chk("single_ready", 32'(req_ready), 32'h1);
      exp_q.push_back('{r: 5'd5, d: 32'h0000_1234, b: 1'b0});
      step();
      req_valid = 3'b000;
      @(negedge clk);
      chk("single_w_en", 32'(w_en), 32'h1);
      chk("single_busy_after", 32'(busy1), 32'h0);
`ifdef GPR_WB_BYPASS_EN
      chk("byp_hit1", 32'(byp_hit1), 32'h1);
      chk("byp_data", byp_data, 32'h0000_1234);
`endif
      step();
      @(negedge clk);
      chk("single_idle_after", 32'(idle), 32'h1);

      // Register-0 write from requester 2 (pointer 1 -> 0 afterwards)
      req_valid = 3'b100;
      req_reg   = {5'd0, 5'd0, 5'd0};
      req_data  = {32'hFFFF_FFFF, 32'h0, 32'h0};
      @(negedge clk);
      chk("r0_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = 3'b000;
      @(negedge clk);
      chk("r0_w_en", 32'(w_en), 32'h0);
      step();

      // Round-robin burst, all three continuously valid
      req_valid = 3'b111;
      req_reg   = {5'd12, 5'd11, 5'd10};
      req_data  = {32'hA2, 32'hA1, 32'hA0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_grant", 32'(req_ready), 32'(1 << (i % 3)));
         if (i > 0) chk("rr_no_gap", 32'(w_en), 32'h1);
         exp_q.push_back('{r: 5'(10 + i % 3), d: 32'(32'hA0 + i % 3), b: 1'b0});
         step();
      end
      req_valid = 3'b000;
      @(negedge clk);
      chk("rr_last_w_en", 32'(w_en), 32'h1);
      step();

      // Set/clear collision on reg 7
      sb_set_en  = 1'b1;
      sb_set_reg = 5'd7;
      step();
      req_valid = 3'b010;
      req_reg   = {5'd0, 5'd7, 5'd0};
      req_data  = {32'h0, 32'h77, 32'h0};
      @(negedge clk);
      chk("coll_ready", 32'(req_ready), 32'h2);
      exp_q.push_back('{r: 5'd7, d: 32'h77, b: 1'b0});
      step();
      req_valid = 3'b000;
      sb_set_en = 1'b0;
      rreg2     = 5'd7;
      @(negedge clk);
      chk("coll_busy2", 32'(busy2), 32'h1);
      step();

      // Byte write without reset
      req_valid = 3'b010;
      req_reg   = {5'd0, 5'd3, 5'd0};
      req_data  = {32'h0, 32'h0000_00AB, 32'h0};
      req_byte  = 3'b010;
      @(negedge clk);
      chk("byte_ready", 32'(req_ready), 32'h2);
      exp_q.push_back('{r: 5'd3, d: 32'h0000_00AB, b: 1'b1});
      step();
      req_valid = 3'b000;
      @(negedge clk);
      step();

      // Same request with reset asserted in the grant cycle
      req_valid = 3'b010;
      rstn      = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(req_ready), 32'h0);
      step();
      rstn      = 1'b1;
      req_valid = 3'b000;
      @(negedge clk);
      chk("rst_mid_w_en", 32'(w_en), 32'h0);
      chk("rst_mid_idle", 32'(idle), 32'h1);
      chk("rst_mid_busy2", 32'(busy2), 32'h0);
      step();
      req_valid = 3'b010;
      @(negedge clk);
      chk("rst_repr_ready", 32'(req_ready), 32'h2);
      exp_q.push_back('{r: 5'd3, d: 32'h0000_00AB, b: 1'b1});
      step();
      req_valid = 3'b000;
      req_byte  = 3'b000;
      @(negedge clk);
      step();

      // Fixed priority instance: requester 1 before requester 0
      fp_valid = 3'b011;
      fp_reg   = {5'd0, 5'd21, 5'd20};
      fp_data  = {32'h0, 32'h21, 32'h20};
      @(negedge clk);
      chk("fp_first", 32'(fp_ready), 32'h2);
      step();
      fp_valid = 3'b001;
      @(negedge clk);
      chk("fp_second", 32'(fp_ready), 32'h1);
      chk("fp_w_en", 32'(fp_w_en), 32'h1);
      chk("fp_wreg1", 32'(fp_wreg), 32'd21);
      step();
      fp_valid = 3'b000;
      @(negedge clk);
      chk("fp_wreg0", 32'(fp_wreg), 32'd20);
      chk("fp_wdata0", fp_wdata, 32'h20);
      step();

      repeat (3) step();
      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
